// File: rtl/bloom_pkg.sv
// rtl/bloom_pkg.sv - shared types and hash helpers for the Bloom hash generator
package bloom_pkg;

    localparam int DEF_STR_LEN    = 8;
    localparam int DEF_HASH_CNT   = 10;
    localparam int DEF_HASH_WIDTH = 12;
    localparam int DEF_POS_WIDTH  = 32;

    typedef logic [7:0] byte_t;
    typedef logic [DEF_HASH_CNT-1:0][DEF_HASH_WIDTH-1:0] hash_vec_t;

    // Per-hash byte key: 0x1F * (k+1), truncated to a byte.
    function automatic byte_t hash_key(input int unsigned k);
        int unsigned prod;
        prod = 32'h1F * (k + 32'd1);
        return byte_t'(prod);
    endfunction

    // Rotate the low w bits of v left by amt; bits at and above w are zero.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned amt,
                                         input int unsigned w);
        logic [31:0] r;
        logic [4:0]  src;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                src  = 5'((i + w - (amt % w)) % w);
                r[i] = v[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bloom_hash_core.sv
// rtl/bloom_hash_core.sv - combinational hash of one window for a single hash index
module bloom_hash_core
    import bloom_pkg::*;
#(
    parameter int STR_LEN    = DEF_STR_LEN,
    parameter int HASH_WIDTH = DEF_HASH_WIDTH,
    parameter int K_IDX      = 0
) (
    input  logic [STR_LEN-1:0][7:0]  window,
    output logic [HASH_WIDTH-1:0]    hash
);

    localparam byte_t KEY = hash_key(K_IDX);

    logic [HASH_WIDTH-1:0] term;

    // Byte j (0 = newest) is keyed, then rotated by 3*j + k so equal bytes
    // at different window positions do not cancel each other out.
    always_comb begin
        hash = '0;
        term = '0;
        for (int j = 0; j < STR_LEN; j++) begin
            term = HASH_WIDTH'(rotl(32'(window[j] ^ KEY), (3 * j + K_IDX) % HASH_WIDTH,
                                    HASH_WIDTH));
            hash = hash ^ term;
        end
    end

endmodule

// File: rtl/bloom_hash_gen.sv
// rtl/bloom_hash_gen.sv - sliding-window multi-hash generator; BLOOM_HASH_STATS_EN adds stat counters
module bloom_hash_gen
    import bloom_pkg::*;
#(
    parameter int STR_LEN    = DEF_STR_LEN,
    parameter int HASH_CNT   = DEF_HASH_CNT,
    parameter int HASH_WIDTH = DEF_HASH_WIDTH,
    parameter int POS_WIDTH  = DEF_POS_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [7:0]                         data_i,
    input  logic                               data_val_i,
    input  logic                               sof_i,
    output logic                               data_rdy_o,
    input  logic                               long_clr_i,
    input  logic                               wr_pend_i,
    output logic [HASH_CNT-1:0][HASH_WIDTH-1:0] hash_o,
    output logic                               hash_val_o,
    output logic [POS_WIDTH-1:0]               pos_o
`ifdef BLOOM_HASH_STATS_EN
    ,
    output logic [31:0]                        stat_hash_cnt_o,
    output logic [31:0]                        stat_stall_cnt_o
`endif
);

    localparam int FW = $clog2(STR_LEN + 1);

    logic                               accept;
    logic                               gap_done;
    logic                               gap_set;
    logic [STR_LEN-1:0][7:0]            win_q;
    logic [STR_LEN-1:0][7:0]            win_next;
    logic [FW-1:0]                      fill_cnt;
    logic [FW-1:0]                      fill_next;
    logic [POS_WIDTH-1:0]               pos_cnt;
    logic [POS_WIDTH-1:0]               pos_next;
    logic                               win_new;
    logic [STR_LEN-1:0][7:0]            s1_win;
    logic                               s1_val;
    logic [POS_WIDTH-1:0]               s1_pos;
    logic [HASH_CNT-1:0][HASH_WIDTH-1:0] hash_c;

    assign accept  = data_val_i && data_rdy_o;
    // A cycle already spent with ready low counts as the gap for this write.
    assign gap_set = gap_done || !data_rdy_o;

    always_comb begin
        win_next  = {win_q[STR_LEN-2:0], data_i};
        fill_next = (fill_cnt == FW'(STR_LEN)) ? fill_cnt : fill_cnt + 1'b1;
        pos_next  = pos_cnt + 1'b1;
        if (sof_i) begin
            win_next    = '0;
            win_next[0] = data_i;
            fill_next   = FW'(1);
            pos_next    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_rdy_o <= 1'b0;
            gap_done   <= 1'b0;
            win_q      <= '0;
            fill_cnt   <= '0;
            pos_cnt    <= '0;
            win_new    <= 1'b0;
            s1_win     <= '0;
            s1_val     <= 1'b0;
            s1_pos     <= '0;
            hash_o     <= '0;
            hash_val_o <= 1'b0;
            pos_o      <= '0;
        end else begin
            data_rdy_o <= !long_clr_i && !(wr_pend_i && !gap_set);
            gap_done   <= wr_pend_i && gap_set;
            if (accept) begin
                win_q    <= win_next;
                fill_cnt <= fill_next;
                pos_cnt  <= pos_next;
            end
            win_new    <= accept && (fill_next == FW'(STR_LEN));
            s1_win     <= win_q;
            s1_val     <= win_new;
            s1_pos     <= pos_cnt;
            hash_o     <= hash_c;
            hash_val_o <= s1_val;
            pos_o      <= s1_pos;
        end
    end

    for (genvar k = 0; k < HASH_CNT; k++) begin : g_core
        bloom_hash_core #(
            .STR_LEN    (STR_LEN),
            .HASH_WIDTH (HASH_WIDTH),
            .K_IDX      (k)
        ) u_core (
            .window (s1_win),
            .hash   (hash_c[k])
        );
    end

`ifdef BLOOM_HASH_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_hash_cnt_o  <= '0;
            stat_stall_cnt_o <= '0;
        end else if (accept && sof_i) begin
            stat_hash_cnt_o  <= '0;
            stat_stall_cnt_o <= '0;
        end else begin
            if (hash_val_o && stat_hash_cnt_o != 32'hFFFF_FFFF)
                stat_hash_cnt_o <= stat_hash_cnt_o + 32'd1;
            if (data_val_i && !data_rdy_o && stat_stall_cnt_o != 32'hFFFF_FFFF)
                stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bloom_hash_gen.sv
// tb/tb_bloom_hash_gen.sv - self-checking bench for bloom_hash_gen against a frame-level model
module tb_bloom_hash_gen;

    localparam int SL = 4;
    localparam int HC = 2;
    localparam int HW = 12;
    localparam int PW = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [7:0]              data_i;
    logic                    data_val_i;
    logic                    sof_i;
    logic                    data_rdy_o;
    logic                    long_clr_i;
    logic                    wr_pend_i;
    logic [HC-1:0][HW-1:0]   hash_o;
    logic                    hash_val_o;
    logic [PW-1:0]           pos_o;
`ifdef BLOOM_HASH_STATS_EN
    logic [31:0]             stat_hash_cnt;
    logic [31:0]             stat_stall_cnt;
`endif

    always #5 clk_i = ~clk_i;

    bloom_hash_gen #(
        .STR_LEN    (SL),
        .HASH_CNT   (HC),
        .HASH_WIDTH (HW),
        .POS_WIDTH  (PW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .sof_i      (sof_i),
        .data_rdy_o (data_rdy_o),
        .long_clr_i (long_clr_i),
        .wr_pend_i  (wr_pend_i),
        .hash_o     (hash_o),
        .hash_val_o (hash_val_o),
        .pos_o      (pos_o)
`ifdef BLOOM_HASH_STATS_EN
        ,
        .stat_hash_cnt_o  (stat_hash_cnt),
        .stat_stall_cnt_o (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic                  val;
        logic [HC-1:0][HW-1:0] h;
        logic [PW-1:0]         pos;
    } exp_t;

    int            vectors = 0;
    int            miscompares = 0;
    logic [7:0]    frame_q[$];
    logic [PW-1:0] m_pos;
    exp_t          pipe[3];

    // Hash of the last SL bytes of the current frame, straight from the arithmetic definition.
    function automatic logic [HW-1:0] ref_hash(input int k);
        int unsigned key, v, r, acc;
        key = (31 * (k + 1)) % 256;
        acc = 0;
        for (int j = 0; j < SL; j++) begin
            v   = (32'(frame_q[frame_q.size() - 1 - j]) ^ key) & 32'hFF;
            r   = (3 * j + k) % HW;
            acc = acc ^ (((v << r) | (v >> (HW - r))) & ((32'd1 << HW) - 1));
        end
        return HW'(acc);
    endfunction

    task automatic model_reset();
        frame_q.delete();
        m_pos = '0;
        for (int i = 0; i < 3; i++) begin
            pipe[i].val = 1'b0;
            pipe[i].h   = '0;
            pipe[i].pos = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, clock, advance the model, check the outputs.
    task automatic cyc(input logic v, input logic s, input logic [7:0] d);
        logic a;
        exp_t e;
        data_val_i = v;
        sof_i      = s;
        data_i     = d;
        a          = v && data_rdy_o;
        @(posedge clk_i);
        e.val = 1'b0;
        e.h   = '0;
        e.pos = '0;
        if (a) begin
            if (s) begin
                frame_q.delete();
                m_pos = '0;
            end else begin
                m_pos = m_pos + 1'b1;
            end
            frame_q.push_back(d);
            if (frame_q.size() > SL) void'(frame_q.pop_front());
            if (frame_q.size() == SL) begin
                e.val = 1'b1;
                for (int k = 0; k < HC; k++) e.h[k] = ref_hash(k);
                e.pos = m_pos;
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        #1;
        chk("hash_val", 64'(hash_val_o), 64'(pipe[2].val));
        if (pipe[2].val) begin
            chk("hash", 64'(hash_o), 64'(pipe[2].h));
            chk("pos", 64'(pos_o), 64'(pipe[2].pos));
        end
    endtask

    initial begin
        int low_cnt;
        int gap_cnt;
        rst_i      = 1'b1;
        data_i     = '0;
        data_val_i = 1'b0;
        sof_i      = 1'b0;
        long_clr_i = 1'b0;
        wr_pend_i  = 1'b0;
        model_reset();
        #12;
        chk("rst_rdy", 64'(data_rdy_o), 64'd0);
        chk("rst_val", 64'(hash_val_o), 64'd0);
        chk("rst_hash", 64'(hash_o), 64'd0);
        chk("rst_pos", 64'(pos_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        chk("rdy_first_edge", 64'(data_rdy_o), 64'd1);

        // Four identical key bytes cancel to zero for hash 0.
        cyc(1'b1, 1'b1, 8'h1F);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h1F);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t1_val", 64'(hash_val_o), 64'd1);
        chk("t1_hash0", 64'(hash_o[0]), 64'h000);
        chk("t1_pos", 64'(pos_o), 64'd3);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        cyc(1'b1, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h5A);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t2_hash0", 64'(hash_o[0]), 64'h925);
        chk("t2_pos", 64'(pos_o), 64'd3);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t2_val5", 64'(hash_val_o), 64'd1);
        chk("t2_pos5", 64'(pos_o), 64'd4);
        cyc(1'b0, 1'b0, 8'h00);

        // sof on the third byte restarts the window.
        cyc(1'b1, 1'b1, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b1, 8'h33);
        cyc(1'b1, 1'b0, 8'h44);
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h66);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t3_val", 64'(hash_val_o), 64'd1);
        chk("t3_pos", 64'(pos_o), 64'd3);

        // Pending write: one ready bubble, then the stream resumes under wr_pend.
        cyc(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom));
        wr_pend_i = 1'b1;
        low_cnt   = 0;
        gap_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom));
            if (!data_rdy_o) low_cnt++;
            if (!hash_val_o) gap_cnt++;
        end
        chk("wr_resume_val", 64'(hash_val_o), 64'd1);
        wr_pend_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom));
            if (!hash_val_o) gap_cnt++;
        end
        chk("wr_rdy_low", 64'(low_cnt), 64'd1);
        chk("wr_gap", 64'(gap_cnt >= 1), 64'd1);

        // Long clear stalls input; window survives the stall.
        long_clr_i = 1'b1;
        low_cnt    = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom));
            if (!data_rdy_o) low_cnt++;
        end
        long_clr_i = 1'b0;
        chk("clr_rdy_low", 64'(low_cnt), 64'd100);
        cyc(1'b1, 1'b0, 8'($urandom));
        chk("clr_rdy_back", 64'(data_rdy_o), 64'd1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'($urandom));

        // Asynchronous reset mid-frame.
        #2;
        rst_i = 1'b1;
        #1;
        chk("mrst_rdy", 64'(data_rdy_o), 64'd0);
        chk("mrst_val", 64'(hash_val_o), 64'd0);
        chk("mrst_hash", 64'(hash_o), 64'd0);
        chk("mrst_pos", 64'(pos_o), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc(1'b1, 1'b1, 8'($urandom));
        chk("mrst_rdy_back", 64'(data_rdy_o), 64'd1);
        cyc(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional sof, write-pend and clear activity.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) wr_pend_i = ~wr_pend_i;
            if ($urandom_range(0, 63) == 0) long_clr_i = ~long_clr_i;
            cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 19) == 0), 8'($urandom));
        end
        wr_pend_i  = 1'b0;
        long_clr_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
